// File: rtl/demux4_pkg.sv
// demux4 shared definitions.
// Channel count, default word width, counter sizing.
package demux4_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W_DEF = 8;

  // Bits needed to count 0..w-1, i.e. ceil(log2(w)).
  function automatic int cnt_w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux4_lane.sv
// demux4 lane: serial assembly into a one-word
// holding register with valid/ready and sticky overflow.
module demux4_lane
  import demux4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              d,
  input  logic              ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              ovf
);

  localparam int CW = cnt_w(DATA_W);

  logic [DATA_W-2:0] sh;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] word;
  logic              last;
  logic              take;
  logic              load;
  logic              drop;

  assign word = {sh, d};
  assign last = en && (cnt == CW'(DATA_W - 1));
  assign take = valid && ready;
  assign load = last && (!valid || take);
  assign drop = last && valid && !ready;

  // Shift the routed bit in MSB-first and count it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (en) begin
      sh  <= word[DATA_W-2:0];
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Holding register; a fresh load wins over consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= word;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

  // Sticky overflow; a new overflow beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_deser.sv
// demux4 top: one-hot select decode of {s0,s1}
// feeding four independent assembly lanes.
module demux4_deser
  import demux4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       d,
  input  logic                       s0,
  input  logic                       s1,
  input  logic                       d_valid,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH-1:0]          ch_ovf,
  input  logic                       ovf_clr
);

  logic [NUM_CH-1:0] en;

  // Only the addressed lane sees a qualified bit.
  always_comb begin
    en = '0;
    unique case ({s0, s1})
      2'b00: en[0] = d_valid;
      2'b01: en[1] = d_valid;
      2'b10: en[2] = d_valid;
      2'b11: en[3] = d_valid;
      default: en = '0;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    demux4_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[k]),
      .d      (d),
      .ready  (ch_ready[k]),
      .ovf_clr(ovf_clr),
      .data   (ch_data[k*DATA_W +: DATA_W]),
      .valid  (ch_valid[k]),
      .ovf    (ch_ovf[k])
    );
  end

endmodule

// File: tb/tb_demux4_deser.sv
// demux4_deser bench: directed scenarios plus random
// traffic against a word-level model and scoreboard.
module tb_demux4_deser;

  localparam int W = 8;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           d = 0;
  logic           s0 = 0;
  logic           s1 = 0;
  logic           d_valid = 0;
  logic           ovf_clr = 0;
  logic [3:0]     ch_ready = 0;
  logic [4*W-1:0] ch_data;
  logic [3:0]     ch_valid;
  logic [3:0]     ch_ovf;

  int checks = 0;
  int errors = 0;

  int         m_acc [4];
  int         m_cnt [4];
  logic [W-1:0] m_hold [4];
  logic       m_full [4];
  logic       m_ovf [4];
  logic [W-1:0] q [4][$];

  demux4_deser #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .s0      (s0),
    .s1      (s1),
    .d_valid (d_valid),
    .ch_data (ch_data),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .ch_ovf  (ch_ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_hold[k] = '0;
      m_full[k] = 0;
      m_ovf[k] = 0;
      q[k].delete();
    end
  endtask

  task automatic model_step(input logic dd,
                            input int ch,
                            input logic dv,
                            input logic [3:0] rdy,
                            input logic clr);
    for (int k = 0; k < 4; k++) begin
      logic take;
      logic done;
      logic [W-1:0] word;
      take = m_full[k] && rdy[k];
      done = 0;
      word = '0;
      if (dv && ch == k) begin
        m_acc[k] = ((m_acc[k] << 1) | int'(dd))
                   & ((1 << W) - 1);
        m_cnt[k]++;
        if (m_cnt[k] == W) begin
          m_cnt[k] = 0;
          done = 1;
          word = W'(m_acc[k]);
        end
      end
      if (done && m_full[k] && !take) m_ovf[k] = 1;
      else if (clr) m_ovf[k] = 0;
      if (done && !(m_full[k] && !take)) begin
        m_hold[k] = word;
        m_full[k] = 1;
        q[k].push_back(word);
      end else if (take) begin
        m_full[k] = 0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] ev;
    logic [3:0] eo;
    logic [4*W-1:0] ed;
    for (int k = 0; k < 4; k++) begin
      ev[k] = m_full[k];
      eo[k] = m_ovf[k];
      ed[k*W +: W] = m_hold[k];
    end
    chk({tag, "_valid"}, 32'(ch_valid), 32'(ev));
    chk({tag, "_ovf"}, 32'(ch_ovf), 32'(eo));
    chk({tag, "_data"}, ch_data, ed);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic dd,
                      input int ch,
                      input logic dv,
                      input logic [3:0] rdy,
                      input logic clr);
    logic [1:0] c;
    c = ch[1:0];
    d = dd;
    s0 = c[1];
    s1 = c[0];
    d_valid = dv;
    ch_ready = rdy;
    ovf_clr = clr;
    model_step(dd, ch, dv, rdy, clr);
    @(posedge clk);
    #1;
    check_state("cyc");
  endtask

  task automatic send(input int ch,
                      input logic [W-1:0] w,
                      input logic [3:0] rdy,
                      input logic [3:0] rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], ch, 1'b1,
           (i == 0) ? rdy_last : rdy, 1'b0);
    end
  endtask

  // Scoreboard: every handshake must hand over the
  // oldest word the model says was loaded.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (ch_valid[k] && ch_ready[k]) begin
          if (q[k].size() == 0) begin
            chk("sb_unexpected", 32'(k), 32'hFFFF_FFFF);
          end else begin
            chk("sb_word",
                32'(ch_data[k*W +: W]),
                32'(q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4*W-1:0] snap_d;
    logic [3:0] snap_v;
    logic [3:0] snap_o;

    model_reset();
    #12;
    chk("rst_valid", 32'(ch_valid), 32'h0);
    chk("rst_ovf", 32'(ch_ovf), 32'h0);
    chk("rst_data", ch_data, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check_state("post_rst");

    // Single word on ch2, nobody consuming.
    send(2, 8'hA5, 4'b0000, 4'b0000);
    chk("a5_valid", 32'(ch_valid), 32'h4);
    chk("a5_data", ch_data, 32'h00A5_0000);

    // Interleaved ch0/ch3, consumers always ready.
    a = 8'h3C;
    b = 8'hF0;
    for (int i = W - 1; i >= 0; i--) begin
      step(a[i], 0, 1'b1, 4'b1111, 1'b0);
      if (i == 0) begin
        chk("il_v0", 32'(ch_valid[0]), 32'h1);
        chk("il_d0", 32'(ch_data[7:0]), 32'h3C);
      end
      step(b[i], 3, 1'b1, 4'b1111, 1'b0);
      if (i == 0) begin
        chk("il_v0_gone", 32'(ch_valid[0]), 32'h0);
        chk("il_v3", 32'(ch_valid[3]), 32'h1);
        chk("il_d3", 32'(ch_data[31:24]), 32'hF0);
      end
    end
    step(1'b0, 0, 1'b0, 4'b1111, 1'b0);
    chk("il_idle", 32'(ch_valid), 32'h0);

    // Overflow on ch1, then clear.
    send(1, 8'h11, 4'b0000, 4'b0000);
    send(1, 8'h22, 4'b0000, 4'b0000);
    chk("ovf_flag", 32'(ch_ovf), 32'h2);
    chk("ovf_hold", 32'(ch_data[15:8]), 32'h11);
    step(1'b0, 0, 1'b0, 4'b0000, 1'b1);
    chk("ovf_clr", 32'(ch_ovf), 32'h0);

    // Reload in the same cycle as consumption.
    send(1, 8'h22, 4'b0000, 4'b0010);
    chk("reload_v", 32'(ch_valid[1]), 32'h1);
    chk("reload_d", 32'(ch_data[15:8]), 32'h22);
    chk("reload_ovf", 32'(ch_ovf), 32'h0);
    step(1'b0, 0, 1'b0, 4'b1111, 1'b0);

    // Reset in the middle of a ch2 word.
    for (int i = 0; i < 5; i++)
      step(1'b1, 2, 1'b1, 4'b0000, 1'b0);
    #2;
    d_valid = 0;
    ch_ready = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(ch_valid), 32'h0);
    chk("mid_rst_data", ch_data, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check_state("rst2");
    send(2, 8'h81, 4'b0000, 4'b0000);
    chk("rst_word", 32'(ch_data[23:16]), 32'h81);
    chk("rst_ovf0", 32'(ch_ovf), 32'h0);

    // Unqualified activity must change nothing.
    snap_d = ch_data;
    snap_v = ch_valid;
    snap_o = ch_ovf;
    for (int i = 0; i < 20; i++)
      step(1'($urandom), int'($urandom % 4),
           1'b0, 4'b0000, 1'b0);
    chk("idle_d", ch_data, snap_d);
    chk("idle_v", 32'(ch_valid), 32'(snap_v));
    chk("idle_o", 32'(ch_ovf), 32'(snap_o));
    send(0, 8'h5A, 4'b0000, 4'b0000);
    chk("idle_after", 32'(ch_data[7:0]), 32'h5A);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom),
           int'($urandom % 4),
           1'(($urandom % 4) != 0),
           4'($urandom),
           1'(($urandom % 16) == 0));
    end

    // Drain what is still held.
    for (int i = 0; i < 3; i++)
      step(1'b0, 0, 1'b0, 4'b1111, 1'b0);
    chk("drain", 32'(ch_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux4_deser.md
DEMUX4_DESER -- requirements
Module: demux4_deser

Interface
REQ-001 Parameter: DATA_W, default 8, width of each assembled channel word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d  input  1  serial data bit to be routed.
REQ-005 s0  input  1  channel select MSB.
REQ-006 s1  input  1  channel select LSB.
REQ-007 d_valid  input  1  qualifies d/s0/s1 in the current cycle.
REQ-008 ch_data  output  4*DATA_W  assembled words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 ch_valid  output  4  per-channel word-available flag.
REQ-010 ch_ready  input  4  per-channel consumer acceptance.
REQ-011 ch_ovf  output  4  per-channel sticky overflow flag.
REQ-012 ovf_clr  input  1  synchronous clear of all ch_ovf bits.

Function
REQ-013 Channel index SHALL be {s0,s1}: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
REQ-014 When d_valid=1, d SHALL be shifted MSB-first into the selected channel's shift register and that channel's bit counter SHALL increment; when d_valid=0, no lane changes shift state.
REQ-015 Unselected channels SHALL hold shift register and counter unchanged, so interleaved bits per channel assemble independently.
REQ-016 Bit counter width SHALL be ceil(log2(DATA_W)); it wraps to 0 on the DATA_W-th bit.
REQ-017 On the DATA_W-th bit, if the holding register is empty, or ch_valid&ch_ready in that same cycle, the full word SHALL load into the holding register and ch_valid SHALL be 1 the following cycle (latency 1 cycle from last bit).
REQ-018 On the DATA_W-th bit with holding register full and not consumed that cycle, the word SHALL be discarded, holding data unchanged, ch_ovf set next cycle, counter wrapped to 0.
REQ-019 ch_valid SHALL remain 1 and ch_data stable until ch_valid&ch_ready; ch_valid then clears next cycle unless REQ-017 reloads in the same cycle (load wins, ch_valid stays 1, new data).
REQ-020 ch_ovf SHALL be sticky until ovf_clr=1; if ovf_clr and a new overflow coincide, the overflow wins (bit stays 1).
REQ-021 ch_ready SHALL have no effect when ch_valid=0; no combinational path from ch_ready to ch_valid or ch_data.
REQ-022 ch_data of an empty channel SHALL hold its last value (zero after reset).

Reset
REQ-023 On rst_n=0, asynchronously: all shift registers, counters, ch_data, ch_valid, ch_ovf SHALL be 0.
REQ-024 A partially assembled word at reset assertion SHALL be lost; after deassertion, assembly restarts at bit 0 on every channel.
REQ-025 Reset deassertion SHALL take effect on the next rising clk edge; no output glitches while rst_n=0.

Structure
REQ-026 A shared package demux4_pkg SHALL hold NUM_CH=4, DATA_W default, and the counter-width function.
REQ-027 One sub-module demux4_lane (shift register, counter, holding register, valid, overflow) SHALL be instantiated NUM_CH times; top level contains only select decode and wiring.
REQ-028 Select decode SHALL produce a one-hot lane enable equal to d_valid AND the decoded {s0,s1}.

Verification
REQ-029 Reset, then 8 bits 1,0,1,0,0,1,0,1 on sel=10 with ch_ready=0 -> cycle after 8th bit ch_valid=0100, ch2 data=0xA5, other channels 0.
REQ-030 Interleave ch0 bits of 0x3C and ch3 bits of 0xF0 alternately, ch_ready=1111 -> both words delivered intact, each one cycle after its own 8th bit, valid for exactly one cycle.
REQ-031 Fill ch1 with 0x11, ch_ready=0, then send 0x22 -> ch1 data stays 0x11, ch_ovf=0010; assert ovf_clr -> ch_ovf=0000.
REQ-032 ch1 holding 0x11, ch_ready[1]=1 in same cycle as 8th bit of 0x22 -> no overflow, ch_valid[1] stays 1, data becomes 0x22.
REQ-033 Assert rst_n=0 after 5 bits on ch2, release, send full 0x81 -> ch2 data=0x81, no remnant bits, all ovf 0.
REQ-034 d_valid=0 with toggling d/s0/s1 for 20 cycles -> no output or internal state change.
